multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Main control FSM that sequences a multicycle MIPS datapath. The datapath shares one memory for instructions and data and one ALU for all arithmetic. The block decodes opcode/funct and drives every mux select and write enable, one microstep per clock. It also stalls on a memory-ready handshake and flags unsupported opcodes.

Parameters:
STATE_W, 4, width of state register (12 states used)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  6  Instr[31:26] from instruction register
funct  input  6  Instr[5:0] from instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory access completes this cycle
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemWrite  output  1  data memory write enable
IRWrite  output  1  instruction register load
PCEn  output  1  PC register load
PCSrc  output  2  next PC: 00=ALUResult, 01=ALUOut, 10=jump target
ALUSrcA  output  1  0=PC, 1=register A
ALUSrcB  output  2  00=B, 01=constant 4, 10=SignImm, 11=SignImm<<2
ALUControl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
RegDst  output  1  0=rt, 1=rd
MemtoReg  output  1  0=ALUOut, 1=Data
RegWrite  output  1  register file write enable
illegal_op  output  1  one-cycle pulse on unsupported opcode
state  output  STATE_W  current state, for debug and verification

Behaviour:
- Reset (async): state <= FETCH immediately. While reset=1, PCEn, IRWrite, MemWrite, RegWrite and illegal_op are forced 0; the other outputs take their FETCH values.
- Outputs are Moore-decoded from state, with two exceptions:
  - PCEn = PCWrite | (Branch & zero).
  - Memory-state enables are gated by mem_ready.
- States, with asserted controls and transitions:
  - FETCH(0): IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSrc=00. IRWrite=PCWrite=mem_ready. If mem_ready=0, hold FETCH; otherwise go to DECODE.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=add (branch target precompute). Next state by opcode:
    - 100011 lw and 101011 sw -> MEMADR
    - 000000 R-type -> EXECUTE
    - 000100 beq -> BRANCH
    - 001000 addi -> ADDIEXEC
    - 000010 j -> JUMP
    - any other opcode -> FETCH, with illegal_op=1 in this cycle only
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, add. lw -> MEMRD; sw -> MEMWR.
  - MEMRD(3): IorD=1. Hold until mem_ready, then -> MEMWB.
  - MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
  - MEMWR(5): IorD=1, MemWrite=mem_ready. Hold until mem_ready, then -> FETCH.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUOp=funct -> ALUWB.
  - ALUWB(7): RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=sub, Branch=1, PCSrc=01 -> FETCH.
  - ADDIEXEC(9): ALUSrcA=1, ALUSrcB=10, add -> ADDIWB.
  - ADDIWB(10): RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
  - JUMP(11): PCSrc=10, PCWrite=1 -> FETCH.
- Unused encodings 12-15 -> FETCH next cycle. All enables are 0 in those states.
- ALU decoding:
  - ALUOp add -> 010; sub -> 110.
  - funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other funct -> 010; this does not raise illegal_op.
- Don't-care outputs in a state are driven 0. No output is ever X.
- Reset asserted mid-instruction aborts it. No partial write may occur after reset rises.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encodings
  - opcode and funct constants
  - ALUOp codes (00 add, 01 sub, 10 funct)
  - ALUControl codes
  - ALUSrcB and PCSrc select codes
- One combinational sub-module, alu_decoder (ALUOp, funct -> ALUControl), instantiated inside the controller.

Test Plan:
- lw, mem_ready=1 always -> states 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4. IRWrite=1 only in cycle 1.
- sw with mem_ready low 2 cycles in MEMWR -> state 5 held 3 cycles. MemWrite=1 only in the third cycle, then FETCH.
- beq, zero=1 -> in state 8 PCEn=1, PCSrc=01, ALUControl=110. Repeat with zero=0 -> PCEn=0 in state 8.
- R-type funct=101010 -> state 6 with ALUControl=111, then state 7 with RegDst=1, RegWrite=1. funct=100101 -> ALUControl=001.
- opcode=111111 -> illegal_op=1 for exactly one cycle in state 1, then state 0. No RegWrite or MemWrite asserted.
- FETCH with mem_ready=0 for 4 cycles -> state stays 0, IRWrite=PCEn=0. Then assert reset asynchronously mid-MEMWR -> state=0 and MemWrite=0 before the next clock edge.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// funct codes, ALU operation classes and datapath mux select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRd    = 4'd3,
    StMemWb    = 4'd4,
    StMemWr    = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StAddiExec = 4'd9,
    StAddiWb   = 4'd10,
    StJump     = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } alu_op_e;

  localparam logic [2:0] AluCtlAnd = 3'b000;
  localparam logic [2:0] AluCtlOr  = 3'b001;
  localparam logic [2:0] AluCtlAdd = 3'b010;
  localparam logic [2:0] AluCtlSub = 3'b110;
  localparam logic [2:0] AluCtlSlt = 3'b111;

  localparam logic [1:0] SrcBReg    = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSh2 = 2'b11;

  localparam logic [1:0] PcSrcAluResult = 2'b00;
  localparam logic [1:0] PcSrcAluOut    = 2'b01;
  localparam logic [1:0] PcSrcJump      = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and status in, every
// mux select and write enable out, plus the current state for debug.
interface multicycle_controller_if #(
  parameter int unsigned STATE_W = 4
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_ready;
  logic               IorD;
  logic               MemWrite;
  logic               IRWrite;
  logic               PCEn;
  logic [1:0]         PCSrc;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [2:0]         ALUControl;
  logic               RegDst;
  logic               MemtoReg;
  logic               RegWrite;
  logic               illegal_op;
  logic [STATE_W-1:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB, ALUControl,
           RegDst, MemtoReg, RegWrite, illegal_op, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB, ALUControl,
           RegDst, MemtoReg, RegWrite, illegal_op, state
  );
endinterface

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU operation class plus the R-type funct field to the
// 3-bit ALU control code.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = AluCtlAdd;
    case (alu_op)
      AluOpSub: alu_control = AluCtlSub;
      AluOpFunct: begin
        // Unknown funct falls back to add and is not treated as illegal.
        case (funct)
          FunctAdd: alu_control = AluCtlAdd;
          FunctSub: alu_control = AluCtlSub;
          FunctAnd: alu_control = AluCtlAnd;
          FunctOr:  alu_control = AluCtlOr;
          FunctSlt: alu_control = AluCtlSlt;
          default:  alu_control = AluCtlAdd;
        endcase
      end
      default: alu_control = AluCtlAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for a multicycle MIPS datapath: one microstep per clock,
// Moore-decoded controls with memory-ready gating and illegal-opcode flagging.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input logic                     clk,
  input logic                     reset,
  multicycle_controller_if.master ctrl_bus
);

  state_e     state_q, state_d;
  alu_op_e    alu_op;
  logic [2:0] alu_control;
  logic       ir_write, pc_write, branch, mem_write, reg_write, illegal;
  logic       iord, alu_src_a, reg_dst, mem_to_reg;
  logic [1:0] pc_src, alu_src_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = StFetch;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    pc_src     = PcSrcAluResult;
    alu_src_a  = 1'b0;
    alu_src_b  = SrcBReg;
    alu_op     = AluOpAdd;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    case (state_q)
      StFetch: begin
        alu_src_b = SrcBFour;
        ir_write  = ctrl_bus.mem_ready;
        pc_write  = ctrl_bus.mem_ready;
        state_d   = ctrl_bus.mem_ready ? StDecode : StFetch;
      end
      StDecode: begin
        // ALU precomputes the branch target while the opcode is decoded.
        alu_src_b = SrcBImmSh2;
        case (ctrl_bus.opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExecute;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiExec;
          OpJ:        state_d = StJump;
          default: begin
            state_d = StFetch;
            illegal = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
        state_d   = (ctrl_bus.opcode == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        iord    = 1'b1;
        state_d = ctrl_bus.mem_ready ? StMemWb : StMemRd;
      end
      StMemWb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      StMemWr: begin
        iord      = 1'b1;
        mem_write = ctrl_bus.mem_ready;
        state_d   = ctrl_bus.mem_ready ? StFetch : StMemWr;
      end
      StExecute: begin
        alu_src_a = 1'b1;
        alu_op    = AluOpFunct;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_op    = AluOpSub;
        branch    = 1'b1;
        pc_src    = PcSrcAluOut;
      end
      StAddiExec: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        reg_write = 1'b1;
      end
      StJump: begin
        pc_src   = PcSrcJump;
        pc_write = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (ctrl_bus.funct),
    .alu_control (alu_control)
  );

  // Enables are masked by reset so nothing is written once reset rises.
  assign ctrl_bus.IRWrite    = ir_write & ~reset;
  assign ctrl_bus.PCEn       = (pc_write | (branch & ctrl_bus.zero)) & ~reset;
  assign ctrl_bus.MemWrite   = mem_write & ~reset;
  assign ctrl_bus.RegWrite   = reg_write & ~reset;
  assign ctrl_bus.illegal_op = illegal & ~reset;
  assign ctrl_bus.IorD       = iord;
  assign ctrl_bus.PCSrc      = pc_src;
  assign ctrl_bus.ALUSrcA    = alu_src_a;
  assign ctrl_bus.ALUSrcB    = alu_src_b;
  assign ctrl_bus.ALUControl = alu_control;
  assign ctrl_bus.RegDst     = reg_dst;
  assign ctrl_bus.MemtoReg   = mem_to_reg;
  assign ctrl_bus.state      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus
// randomized instruction streams checked against a per-instruction step model.
module tb_multicycle_controller;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;

  multicycle_controller_if #(.STATE_W(4)) bus ();

  multicycle_controller #(.STATE_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .ctrl_bus (bus.master)
  );

  always #5 clk = ~clk;

  // 0 lw, 1 sw, 2 R-type, 3 beq, 4 addi, 5 j, 6 unsupported
  function automatic int classify(input logic [5:0] op);
    case (op)
      LW: return 0;
      SW: return 1;
      RT: return 2;
      BEQ: return 3;
      ADDI: return 4;
      JMP: return 5;
      default: return 6;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected {IorD,MemWrite,IRWrite,PCEn,PCSrc,ALUSrcA,ALUSrcB,ALUControl,
  //           RegDst,MemtoReg,RegWrite,illegal_op} for one microstep.
  function automatic logic [15:0] exp_ctrl(input int st, input logic [5:0] op,
                                           input logic [5:0] fn, input logic z,
                                           input logic rdy);
    logic iord, mw, irw, pcen, srca, regdst, m2r, rw, ill;
    logic [1:0] pcsrc, srcb;
    logic [2:0] aluc;
    {iord, mw, irw, pcen, srca, regdst, m2r, rw, ill} = '0;
    pcsrc = 2'b00;
    srcb  = 2'b00;
    aluc  = 3'b010;
    case (st)
      0: begin srcb = 2'b01; irw = rdy; pcen = rdy; end
      1: begin srcb = 2'b11; ill = (classify(op) == 6); end
      2: begin srca = 1'b1; srcb = 2'b10; end
      3: iord = 1'b1;
      4: begin m2r = 1'b1; rw = 1'b1; end
      5: begin iord = 1'b1; mw = rdy; end
      6: begin srca = 1'b1; aluc = funct_alu(fn); end
      7: begin regdst = 1'b1; rw = 1'b1; end
      8: begin srca = 1'b1; aluc = 3'b110; pcen = z; pcsrc = 2'b01; end
      9: begin srca = 1'b1; srcb = 2'b10; end
      10: rw = 1'b1;
      11: begin pcsrc = 2'b10; pcen = 1'b1; end
      default: ;
    endcase
    return {iord, mw, irw, pcen, pcsrc, srca, srcb, aluc, regdst, m2r, rw, ill};
  endfunction

  // Advance one cycle: new inputs just after the rising edge, sample at the falling edge.
  task automatic tick(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic rdy);
    @(posedge clk);
    #1;
    bus.opcode    = op;
    bus.funct     = fn;
    bus.zero      = z;
    bus.mem_ready = rdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode    = 6'd0;
    bus.funct     = 6'd0;
    bus.zero      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b1;
    bus.opcode    = LW;
    @(negedge clk);
    n_checks += 4;
    if (bus.state !== 4'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.state);
    end
    if ({bus.IRWrite, bus.PCEn, bus.MemWrite, bus.RegWrite, bus.illegal_op} !== 5'b0) begin
      n_fail++; $display("FAIL reset_enables: got %b expected 00000",
                         {bus.IRWrite, bus.PCEn, bus.MemWrite, bus.RegWrite, bus.illegal_op});
    end
    if (bus.ALUSrcB !== 2'b01) begin
      n_fail++; $display("FAIL reset_alusrcb: got %b expected 01", bus.ALUSrcB);
    end
    if (bus.ALUControl !== 3'b010) begin
      n_fail++; $display("FAIL reset_aluctl: got %b expected 010", bus.ALUControl);
    end
    do_reset();
  endtask

  task automatic test_lw();
    for (int i = 0; i < 5; i++) begin
      tick(LW, 6'd0, 1'b0, 1'b1);
      n_checks += 4;
      if (bus.state !== 4'(i)) begin
        n_fail++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, bus.state, i);
      end
      if (bus.RegWrite !== (i == 4)) begin
        n_fail++; $display("FAIL lw_regwrite[%0d]: got %b expected %b", i, bus.RegWrite, i == 4);
      end
      if (bus.MemtoReg !== (i == 4)) begin
        n_fail++; $display("FAIL lw_memtoreg[%0d]: got %b expected %b", i, bus.MemtoReg, i == 4);
      end
      if (bus.IRWrite !== (i == 0)) begin
        n_fail++; $display("FAIL lw_irwrite[%0d]: got %b expected %b", i, bus.IRWrite, i == 0);
      end
    end
    tick(LW, 6'd0, 1'b0, 1'b0);
    n_checks++;
    if (bus.state !== 4'd0) begin
      n_fail++; $display("FAIL lw_return: got %0d expected 0", bus.state);
    end
  endtask

  task automatic test_sw_stall();
    for (int i = 0; i < 3; i++) tick(SW, 6'd0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick(SW, 6'd0, 1'b0, k == 2);
      n_checks += 2;
      if (bus.state !== 4'd5) begin
        n_fail++; $display("FAIL sw_hold[%0d]: got %0d expected 5", k, bus.state);
      end
      if (bus.MemWrite !== (k == 2)) begin
        n_fail++; $display("FAIL sw_memwrite[%0d]: got %b expected %b", k, bus.MemWrite, k == 2);
      end
    end
    tick(SW, 6'd0, 1'b0, 1'b0);
    n_checks++;
    if (bus.state !== 4'd0) begin
      n_fail++; $display("FAIL sw_return: got %0d expected 0", bus.state);
    end
  endtask

  task automatic test_beq(input logic z);
    tick(BEQ, 6'd0, z, 1'b1);
    tick(BEQ, 6'd0, z, 1'b1);
    tick(BEQ, 6'd0, z, 1'b1);
    n_checks += 4;
    if (bus.state !== 4'd8) begin
      n_fail++; $display("FAIL beq_state: got %0d expected 8", bus.state);
    end
    if (bus.PCEn !== z) begin
      n_fail++; $display("FAIL beq_pcen(z=%b): got %b expected %b", z, bus.PCEn, z);
    end
    if (bus.PCSrc !== 2'b01) begin
      n_fail++; $display("FAIL beq_pcsrc: got %b expected 01", bus.PCSrc);
    end
    if (bus.ALUControl !== 3'b110) begin
      n_fail++; $display("FAIL beq_aluctl: got %b expected 110", bus.ALUControl);
    end
  endtask

  task automatic test_rtype(input logic [5:0] fn, input logic [2:0] alu);
    tick(RT, fn, 1'b0, 1'b1);
    tick(RT, fn, 1'b0, 1'b1);
    tick(RT, fn, 1'b0, 1'b1);
    n_checks += 2;
    if (bus.state !== 4'd6) begin
      n_fail++; $display("FAIL rtype_exec_state: got %0d expected 6", bus.state);
    end
    if (bus.ALUControl !== alu) begin
      n_fail++; $display("FAIL rtype_aluctl(%b): got %b expected %b", fn, bus.ALUControl, alu);
    end
    tick(RT, fn, 1'b0, 1'b1);
    n_checks += 2;
    if (bus.state !== 4'd7) begin
      n_fail++; $display("FAIL rtype_wb_state: got %0d expected 7", bus.state);
    end
    if ({bus.RegDst, bus.RegWrite} !== 2'b11) begin
      n_fail++; $display("FAIL rtype_wb_ctl: got %b expected 11", {bus.RegDst, bus.RegWrite});
    end
  endtask

  task automatic test_illegal();
    tick(6'b111111, 6'd0, 1'b0, 1'b1);
    tick(6'b111111, 6'd0, 1'b0, 1'b1);
    n_checks += 3;
    if (bus.state !== 4'd1) begin
      n_fail++; $display("FAIL illegal_state: got %0d expected 1", bus.state);
    end
    if (bus.illegal_op !== 1'b1) begin
      n_fail++; $display("FAIL illegal_pulse: got %b expected 1", bus.illegal_op);
    end
    if ({bus.RegWrite, bus.MemWrite} !== 2'b00) begin
      n_fail++; $display("FAIL illegal_writes: got %b expected 00", {bus.RegWrite, bus.MemWrite});
    end
    tick(6'b111111, 6'd0, 1'b0, 1'b0);
    n_checks += 2;
    if (bus.state !== 4'd0) begin
      n_fail++; $display("FAIL illegal_return: got %0d expected 0", bus.state);
    end
    if (bus.illegal_op !== 1'b0) begin
      n_fail++; $display("FAIL illegal_one_cycle: got %b expected 0", bus.illegal_op);
    end
  endtask

  task automatic test_fetch_stall_and_reset();
    for (int i = 0; i < 4; i++) begin
      tick(SW, 6'd0, 1'b1, 1'b0);
      n_checks += 2;
      if (bus.state !== 4'd0) begin
        n_fail++; $display("FAIL fetch_stall_state[%0d]: got %0d expected 0", i, bus.state);
      end
      if ({bus.IRWrite, bus.PCEn} !== 2'b00) begin
        n_fail++; $display("FAIL fetch_stall_en[%0d]: got %b expected 00", i,
                           {bus.IRWrite, bus.PCEn});
      end
    end
    tick(SW, 6'd0, 1'b0, 1'b1);
    tick(SW, 6'd0, 1'b0, 1'b1);
    tick(SW, 6'd0, 1'b0, 1'b1);
    tick(SW, 6'd0, 1'b0, 1'b0);
    #2;
    bus.mem_ready = 1'b1;
    #1;
    n_checks += 2;
    if (bus.state !== 4'd5) begin
      n_fail++; $display("FAIL midwr_state: got %0d expected 5", bus.state);
    end
    if (bus.MemWrite !== 1'b1) begin
      n_fail++; $display("FAIL midwr_memwrite: got %b expected 1", bus.MemWrite);
    end
    reset = 1'b1;
    #1;
    n_checks += 2;
    if (bus.state !== 4'd0) begin
      n_fail++; $display("FAIL async_reset_state: got %0d expected 0", bus.state);
    end
    if ({bus.MemWrite, bus.RegWrite} !== 2'b00) begin
      n_fail++; $display("FAIL async_reset_writes: got %b expected 00",
                         {bus.MemWrite, bus.RegWrite});
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [5:0] op, fn;
    logic z, rdy;
    int steps[$];
    int stalls;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0: op = LW;
        1: op = SW;
        2: op = RT;
        3: op = BEQ;
        4: op = ADDI;
        5: op = JMP;
        default: op = 6'($urandom_range(0, 63));
      endcase
      fn = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) fn = {1'b1, 2'b0, 3'($urandom_range(0, 7))};
      steps = {0, 1};
      case (classify(op))
        0: steps = {steps, 2, 3, 4};
        1: steps = {steps, 2, 5};
        2: steps = {steps, 6, 7};
        3: steps = {steps, 8};
        4: steps = {steps, 9, 10};
        5: steps = {steps, 11};
        default: ;
      endcase
      foreach (steps[s]) begin
        stalls = (steps[s] == 0 || steps[s] == 3 || steps[s] == 5) ? $urandom_range(0, 3) : 0;
        for (int c = 0; c <= stalls; c++) begin
          z   = 1'($urandom_range(0, 1));
          rdy = (stalls == 0 && steps[s] != 0 && steps[s] != 3 && steps[s] != 5) ?
                1'($urandom_range(0, 1)) : (c == stalls);
          tick(op, fn, z, rdy);
          n_checks += 2;
          if (bus.state !== 4'(steps[s])) begin
            n_fail++; $display("FAIL rand_state(op=%b): got %0d expected %0d", op, bus.state,
                               steps[s]);
          end
          if ({bus.IorD, bus.MemWrite, bus.IRWrite, bus.PCEn, bus.PCSrc, bus.ALUSrcA,
               bus.ALUSrcB, bus.ALUControl, bus.RegDst, bus.MemtoReg, bus.RegWrite,
               bus.illegal_op} !== exp_ctrl(steps[s], op, fn, z, rdy)) begin
            n_fail++;
            $display("FAIL rand_ctrl(st=%0d op=%b fn=%b): got %b expected %b", steps[s], op, fn,
                     {bus.IorD, bus.MemWrite, bus.IRWrite, bus.PCEn, bus.PCSrc, bus.ALUSrcA,
                      bus.ALUSrcB, bus.ALUControl, bus.RegDst, bus.MemtoReg, bus.RegWrite,
                      bus.illegal_op}, exp_ctrl(steps[s], op, fn, z, rdy));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_beq(1'b1);
    test_beq(1'b0);
    test_rtype(6'b101010, 3'b111);
    test_rtype(6'b100101, 3'b001);
    test_illegal();
    test_fetch_stall_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
